// File: rtl/mod_pkg.sv
// Shared constants and FSM encoding for the word-serial P-256 modular subtractor.
package mod_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int NLIMBS_DEF = 8;

  localparam logic [255:0] P256 =
    256'hFFFFFFFF_00000001_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mod_sub_serial_limb_addsub.sv
// One-limb ripple adder; inverts y when i_sub is set so a subtract is x + ~y + cin.
module limb_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  logic [WIDTH-1:0] w_y;
  logic [WIDTH:0]   w_c;

  assign w_y    = i_sub ? ~i_y : i_y;
  assign w_c[0] = i_cin;

  for (genvar g = 0; g < WIDTH; g++) begin : g_fa
    assign o_sum[g]  = i_x[g] ^ w_y[g] ^ w_c[g];
    assign w_c[g+1]  = (i_x[g] & w_y[g]) | (i_x[g] & w_c[g]) | (w_y[g] & w_c[g]);
  end

  assign o_cout = w_c[WIDTH];

endmodule

// File: rtl/mod_sub_serial.sv
// Word-serial r = (a - b) mod P: one limb per cycle, then a limb-serial add of P
// when the subtract borrows out of the top limb.
module mod_sub_serial
  import mod_pkg::*;
#(
  parameter int                        WIDTH  = WIDTH_DEF,
  parameter int                        NLIMBS = NLIMBS_DEF,
  parameter logic [NLIMBS*WIDTH-1:0]   P      = P256
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic [NLIMBS*WIDTH-1:0]   i_a,
  input  logic [NLIMBS*WIDTH-1:0]   i_b,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [NLIMBS*WIDTH-1:0]   o_result,
  output state_t                    o_dbg_state
);

  localparam int IDX_W = (NLIMBS > 1) ? $clog2(NLIMBS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NLIMBS - 1);
  localparam logic [NLIMBS-1:0][WIDTH-1:0] P_LIMBS = P;

  state_t                        r_state;
  logic [NLIMBS-1:0][WIDTH-1:0]  r_a;
  logic [NLIMBS-1:0][WIDTH-1:0]  r_b;
  logic [NLIMBS-1:0][WIDTH-1:0]  r_result;
  logic [IDX_W-1:0]              r_idx;
  // Holds the borrow during SUB and the carry during FIX.
  logic                          r_cy;
  logic                          r_busy;
  logic                          r_done;

  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic             w_cin;
  logic             w_sub;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  always_comb begin
    w_x   = r_result[r_idx];
    w_y   = P_LIMBS[r_idx];
    w_cin = r_cy;
    w_sub = 1'b0;
    if (r_state == SUB) begin
      w_x   = r_a[r_idx];
      w_y   = r_b[r_idx];
      w_cin = ~r_cy;
      w_sub = 1'b1;
    end
  end

  limb_addsub #(.WIDTH(WIDTH)) u_addsub (
    .i_x    (w_x),
    .i_y    (w_y),
    .i_cin  (w_cin),
    .i_sub  (w_sub),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_idx    <= '0;
      r_cy     <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_a     <= i_a;
            r_b     <= i_b;
            r_cy    <= 1'b0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= SUB;
          end
        end
        SUB: begin
          r_result[r_idx] <= w_sum;
          r_cy            <= ~w_cout;
          if (r_idx == LAST_IDX) begin
            r_idx   <= '0;
            // A borrow out of the top limb means a < b: add P back in FIX.
            r_cy    <= 1'b0;
            r_state <= w_cout ? DONE : FIX;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        FIX: begin
          r_result[r_idx] <= w_sum;
          r_cy            <= w_cout;
          if (r_idx == LAST_IDX) begin
            r_idx   <= '0;
            r_cy    <= 1'b0;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_result    = r_result;
  assign o_dbg_state = r_state;

endmodule
